// File: rtl/spi_slave_pkg.sv
// Shared SPI slave definitions: opcodes, frame FSM states, controller command/response codes.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package spi_slave_pkg;

    // Frame opcodes carried in byte 0 of every SPI frame
    localparam logic [7:0] OP_CMD   = 8'hC0;
    localparam logic [7:0] OP_WDATA = 8'hC2;
    localparam logic [7:0] OP_RESP  = 8'h81;
    localparam logic [7:0] OP_BUFRD = 8'h03;

    // Number of payload bytes following the opcode in CMD/WDATA/RESP frames
    localparam int unsigned WORD_BYTES = 4;

    // Frame decoder state
    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        CMD,
        WDATA,
        RESP,
        BUFRD,
        IGNORE
    } state_e;

    // Command words understood by the controller (carried in CMD frames)
    localparam logic [31:0] CMD_NOP     = 32'h0000_0000;
    localparam logic [31:0] CMD_ARM     = 32'h0000_0001;
    localparam logic [31:0] CMD_TRIGGER = 32'h0000_0002;
    localparam logic [31:0] CMD_STATUS  = 32'h0000_0003;
    localparam logic [31:0] CMD_FLUSH   = 32'h0000_0007;

    // Response words returned by the controller (read back with RESP frames)
    localparam logic [31:0] RESP_IDLE      = 32'h0000_0000;
    localparam logic [31:0] RESP_ARMED     = 32'h0000_0001;
    localparam logic [31:0] RESP_TRIGGERED = 32'h0000_0002;
    localparam logic [31:0] RESP_DONE      = 32'h0000_0005;
    localparam logic [31:0] RESP_ERROR     = 32'h0000_00FF;

    // Byte k (1..4) of a response word, most significant byte first; 0 outside that range
    function automatic logic [7:0] resp_byte(input logic [31:0] word, input logic [2:0] k);
        logic [7:0] b;
        b = 8'h00;
        case (k)
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Frame type selected by the opcode byte; unknown opcodes are swallowed silently
    function automatic state_e decode_opcode(input logic [7:0] op);
        state_e s;
        case (op)
            OP_CMD:   s = CMD;
            OP_WDATA: s = WDATA;
            OP_RESP:  s = RESP;
            OP_BUFRD: s = BUFRD;
            default:  s = IGNORE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, plus single-cycle rise/fall pulses.
// Latency: level 2 clk after the pin; rise/fall pulse during the 3rd clk after the pin edge.
// Backpressure: none; pulses are emitted unconditionally.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Metastability filter followed by a one-cycle history stage for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave: oversamples SCK/SS/MOSI, decodes 5-byte CMD/WDATA/RESP frames and streaming BUFRD reads.
// Latency: strobes 1 clk after the bit-40 SCK rise event; MISO 1 clk (RESP) / 3 clk (BUFRD) after the SCK fall event.
// Backpressure: none; the host paces everything, one FIFO pop is issued per BUFRD byte started.
module spi_frame_slave
    import spi_slave_pkg::*;
#(
    parameter int BUF_W = 8,
    parameter int CMD_W = 32
) (
    input  logic             inclk,
    input  logic             reset_n,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    input  logic             spi_ss,
    output logic             spi_miso,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd_data,
    output logic             wr_valid,
    output logic [CMD_W-1:0] wr_data,
    input  logic [CMD_W-1:0] resp_word,
    output logic             buf_rd_req,
    input  logic [BUF_W-1:0] buf_rd_data,
    output logic             frame_active
);

    // Synchronized pin events
    logic sck_lvl_unused;
    logic sck_rise;
    logic sck_fall;
    logic ss_lvl;
    logic ss_rise;
    logic ss_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk_i  (inclk),
        .rst_ni (reset_n),
        .din_i  (spi_clk),
        .sync_o (sck_lvl_unused),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // SS idles high, so its synchronizer resets to 1 to avoid a spurious frame start
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk_i  (inclk),
        .rst_ni (reset_n),
        .din_i  (spi_ss),
        .sync_o (ss_lvl),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    // MOSI only needs a level: it is stable for many clk around each SCK rise
    logic mosi_meta_q;
    logic mosi_q;

    // Two-flop synchronizer for MOSI, same depth as SCK so data and sample edge stay aligned
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            mosi_meta_q <= spi_mosi;
            mosi_q      <= mosi_meta_q;
        end
    end

    // Frame decoder state
    state_e           state_q,     state_d;
    logic [2:0]       bit_cnt_q,   bit_cnt_d;
    logic [2:0]       byte_cnt_q,  byte_cnt_d;   // saturates at 7; only "0..4 vs beyond" matters
    logic [CMD_W-1:0] rx_q,        rx_d;
    logic [BUF_W-1:0] tx_q,        tx_d;
    logic [CMD_W-1:0] resp_q,      resp_d;
    logic [CMD_W-1:0] cmd_data_q,  cmd_data_d;
    logic [CMD_W-1:0] wr_data_q,   wr_data_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             wr_valid_q,  wr_valid_d;
    logic             rd_req_q,    rd_req_d;
    logic             load_q,      load_d;        // FIFO byte is on buf_rd_data this cycle

    logic [CMD_W-1:0] rx_next;
    logic             byte_done;
    logic             byte_start;

    assign rx_next    = {rx_q[CMD_W-2:0], mosi_q};
    assign byte_done  = (bit_cnt_q == 3'd7);
    // A fall with the bit counter wrapped marks the start of payload byte byte_cnt_q
    assign byte_start = (bit_cnt_q == 3'd0) && (byte_cnt_q != 3'd0);

    // State and datapath registers; reset forces an idle, silent slave
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 3'd0;
            rx_q        <= '0;
            tx_q        <= '0;
            resp_q      <= '0;
            cmd_data_q  <= '0;
            wr_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            resp_q      <= resp_d;
            cmd_data_q  <= cmd_data_d;
            wr_data_q   <= wr_data_d;
            cmd_valid_q <= cmd_valid_d;
            wr_valid_q  <= wr_valid_d;
            rd_req_q    <= rd_req_d;
            load_q      <= load_d;
        end
    end

    // Next-state: SS edges frame everything, SCK rise samples MOSI, SCK fall loads/shifts MISO
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        resp_d      = resp_q;
        cmd_data_d  = cmd_data_q;
        wr_data_d   = wr_data_q;
        cmd_valid_d = 1'b0;
        wr_valid_d  = 1'b0;
        rd_req_d    = 1'b0;
        load_d      = rd_req_q;

        if (ss_rise) begin
            // End or abort of frame: drop any pending FIFO byte, keep held words
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            tx_d       = '0;
            load_d     = 1'b0;
        end else if (ss_fall) begin
            state_d    = OPCODE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            rx_d       = '0;
            tx_d       = '0;
            load_d     = 1'b0;
        end else if (state_q != IDLE) begin
            // FIFO data arrives two cycles after the byte-start fall, well inside the SCK low phase
            if (load_q && (state_q == BUFRD)) begin
                tx_d = buf_rd_data;
            end

            if (sck_rise) begin
                rx_d      = rx_next;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_done) begin
                    if (byte_cnt_q != 3'd7) begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                    if (state_q == OPCODE) begin
                        state_d = decode_opcode(rx_next[7:0]);
                    end
                    // Byte 4 completes bit 40: the shift register now holds exactly the payload word
                    if (byte_cnt_q == 3'd4) begin
                        if (state_q == CMD) begin
                            cmd_valid_d = 1'b1;
                            cmd_data_d  = rx_next;
                        end
                        if (state_q == WDATA) begin
                            wr_valid_d = 1'b1;
                            wr_data_d  = rx_next;
                        end
                    end
                end
            end else if (sck_fall) begin
                if (byte_start) begin
                    case (state_q)
                        RESP: begin
                            // Freeze the response at byte 1 so the 4 bytes are coherent
                            if (byte_cnt_q == 3'd1) begin
                                resp_d = resp_word;
                                tx_d   = BUF_W'(resp_byte(resp_word, 3'd1));
                            end else begin
                                tx_d   = BUF_W'(resp_byte(resp_q, byte_cnt_q));
                            end
                        end
                        BUFRD: begin
                            rd_req_d = 1'b1;
                            tx_d     = '0;
                        end
                        default: tx_d = '0;
                    endcase
                end else begin
                    tx_d = {tx_q[BUF_W-2:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso     = tx_q[BUF_W-1] & ~spi_ss;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_data     = cmd_data_q;
    assign wr_valid     = wr_valid_q;
    assign wr_data      = wr_data_q;
    assign buf_rd_req   = rd_req_q;
    assign frame_active = ~ss_lvl;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Self-checking bench for spi_frame_slave: directed frames plus randomized frames against a frame-level model.
// Latency: host SCK phases of 6..9 inclk; all waits are fixed cycle counts.
// Backpressure: FIFO stub pops a queue on every buf_rd_req.
module tb_spi_frame_slave;

    logic        inclk;
    logic        reset_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_ss;
    logic        spi_miso;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [31:0] resp_word;
    logic        buf_rd_req;
    logic [7:0]  buf_rd_data;
    logic        frame_active;

    int checks = 0;
    int errors = 0;
    int tot_cmdv = 0;
    int tot_wrv  = 0;
    int tot_req  = 0;
    int f_cmdv, f_wrv, f_req;

    logic [31:0] m_cmd;
    logic [31:0] m_wr;
    logic [7:0]  fifo_q[$];
    logic [7:0]  frame_bytes[24];
    logic [7:0]  got_bytes[24];
    logic [7:0]  exp_miso[24];

    spi_frame_slave #(.BUF_W(8), .CMD_W(32)) dut (
        .inclk        (inclk),
        .reset_n      (reset_n),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_ss       (spi_ss),
        .spi_miso     (spi_miso),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .resp_word    (resp_word),
        .buf_rd_req   (buf_rd_req),
        .buf_rd_data  (buf_rd_data),
        .frame_active (frame_active)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    // Capture FIFO stub: data valid the cycle after a pop request
    always @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            buf_rd_data <= 8'h00;
        end else if (buf_rd_req) begin
            if (fifo_q.size() > 0) buf_rd_data <= fifo_q.pop_front();
            else                   buf_rd_data <= 8'hEE;
        end
    end

    // Count strobe cycles; a stretched strobe shows up as an extra count
    always @(negedge inclk) begin
        if (cmd_valid === 1'b1)  tot_cmdv++;
        if (wr_valid === 1'b1)   tot_wrv++;
        if (buf_rd_req === 1'b1) tot_req++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge inclk);
        #1;
    endtask

    // Between frames every output must be quiet and the held words must match the model
    task automatic idle_watch(input int n);
        repeat (n) begin
            @(negedge inclk);
            check("idle_miso", {31'b0, spi_miso}, 32'd0);
            check("idle_frame_active", {31'b0, frame_active}, 32'd0);
            check("idle_strobes", {29'b0, cmd_valid, wr_valid, buf_rd_req}, 32'd0);
            check("idle_cmd_data", cmd_data, m_cmd);
            check("idle_wr_data", wr_data, m_wr);
        end
        #1;
    endtask

    // Mode-0 host: MOSI set in the low phase, MISO sampled just before each rise
    task automatic run_frame(input int nbits, input bit trailing, input bit do_end, input int hp);
        for (int k = 0; k < 24; k++) got_bytes[k] = 8'h00;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_ss   = 1'b0;
        cyc(5);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = frame_bytes[i / 8][7 - (i % 8)];
            cyc(hp);
            got_bytes[i / 8][7 - (i % 8)] = spi_miso;
            check("frame_active", {31'b0, frame_active}, 32'd1);
            spi_clk = 1'b1;
            cyc(hp);
            if (i == 11) resp_word = $urandom;
            if (i < nbits - 1 || trailing) spi_clk = 1'b0;
        end
        if (do_end) begin
            if (trailing) cyc(hp);
            spi_ss = 1'b1;
            cyc(1);
            spi_clk = 1'b0;
            cyc(8);
        end
    endtask

    // Frame-level model: expected strobes, pops and MISO bytes from the opcode rules
    task automatic do_frame(input int nbits, input bit trailing, input int hp);
        logic [31:0] resp0;
        logic [7:0]  snap[$];
        logic [7:0]  op;
        logic [7:0]  mask;
        int e_cmdv, e_wrv, e_req, c0, w0, r0, bits;
        resp0  = resp_word;
        snap   = fifo_q;
        op     = frame_bytes[0];
        e_cmdv = 0;
        e_wrv  = 0;
        e_req  = 0;
        for (int k = 0; k < 24; k++) exp_miso[k] = 8'h00;
        if (nbits >= 8) begin
            if (op == 8'hC0 && nbits >= 40) e_cmdv = 1;
            if (op == 8'hC2 && nbits >= 40) e_wrv = 1;
            if (op == 8'h81) begin
                for (int k = 1; k <= 4; k++) exp_miso[k] = resp0[8 * (4 - k) +: 8];
            end
            if (op == 8'h03) begin
                // one pop for every byte whose starting SCK fall happened with SS low
                for (int i = 8; i <= nbits; i += 8) begin
                    if (i < nbits || trailing) e_req++;
                end
                for (int k = 1; k < 24; k++) exp_miso[k] = (k - 1 < snap.size()) ? snap[k - 1] : 8'hEE;
            end
        end
        c0 = tot_cmdv;
        w0 = tot_wrv;
        r0 = tot_req;
        run_frame(nbits, trailing, 1'b1, hp);
        f_cmdv = tot_cmdv - c0;
        f_wrv  = tot_wrv - w0;
        f_req  = tot_req - r0;
        if (e_cmdv != 0) m_cmd = {frame_bytes[1], frame_bytes[2], frame_bytes[3], frame_bytes[4]};
        if (e_wrv != 0)  m_wr  = {frame_bytes[1], frame_bytes[2], frame_bytes[3], frame_bytes[4]};
        check("cmd_valid_count", f_cmdv, e_cmdv);
        check("wr_valid_count", f_wrv, e_wrv);
        check("buf_rd_req_count", f_req, e_req);
        check("cmd_data", cmd_data, m_cmd);
        check("wr_data", wr_data, m_wr);
        for (int k = 0; k < (nbits + 7) / 8; k++) begin
            bits = (nbits - 8 * k >= 8) ? 8 : nbits - 8 * k;
            mask = 8'hFF << (8 - bits);
            check($sformatf("miso_byte%0d", k), {24'b0, got_bytes[k] & mask}, {24'b0, exp_miso[k] & mask});
        end
        idle_watch(6);
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4);
        for (int k = 0; k < 24; k++) frame_bytes[k] = 8'h00;
        frame_bytes[0] = b0;
        frame_bytes[1] = b1;
        frame_bytes[2] = b2;
        frame_bytes[3] = b3;
        frame_bytes[4] = b4;
    endtask

    initial begin
        logic [7:0] orv;
        reset_n   = 1'b0;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        spi_ss    = 1'b1;
        resp_word = 32'h0;
        m_cmd     = 32'h0;
        m_wr      = 32'h0;
        cyc(3);
        check("rst_miso", {31'b0, spi_miso}, 32'd0);
        check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
        check("rst_cmd_data", cmd_data, 32'd0);
        check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_buf_rd_req", {31'b0, buf_rd_req}, 32'd0);
        check("rst_frame_active", {31'b0, frame_active}, 32'd0);
        reset_n = 1'b1;
        cyc(5);
        idle_watch(4);

        // Command frame
        set_bytes(8'hC0, 8'h00, 8'h00, 8'h00, 8'h03);
        do_frame(40, 1'b1, 6);
        check("lit_cmd_data", cmd_data, 32'h0000_0003);
        check("lit_cmd_pulses", f_cmdv, 32'd1);
        check("lit_cmd_no_wr", f_wrv, 32'd0);

        // Data-register frame leaves the command word alone
        set_bytes(8'hC2, 8'h00, 8'h03, 8'h00, 8'h00);
        do_frame(40, 1'b0, 7);
        check("lit_wr_data", wr_data, 32'h0003_0000);
        check("lit_wr_pulses", f_wrv, 32'd1);
        check("lit_cmd_held", cmd_data, 32'h0000_0003);

        // Response readback; resp_word is changed mid-frame and must not leak in
        resp_word = 32'h0000_0005;
        set_bytes(8'h81, 8'h00, 8'h00, 8'h00, 8'h00);
        do_frame(40, 1'b1, 6);
        for (int k = 0; k < 4; k++) check("lit_resp_zero", {24'b0, got_bytes[k]}, 32'd0);
        check("lit_resp_byte4", {24'b0, got_bytes[4]}, 32'h05);

        // Buffer read of 16 preloaded bytes
        fifo_q.delete();
        for (int k = 0; k < 16; k++) fifo_q.push_back(8'(8'h10 + k));
        for (int k = 0; k < 24; k++) frame_bytes[k] = 8'h00;
        frame_bytes[0] = 8'h03;
        do_frame(136, 1'b0, 6);
        check("lit_bufrd_pops", f_req, 32'd16);
        for (int k = 1; k <= 16; k++) check("lit_bufrd_byte", {24'b0, got_bytes[k]}, 32'(8'h0F + k));

        // Aborted command, then a full one
        set_bytes(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);
        do_frame(24, 1'b1, 6);
        check("lit_abort_no_cmd", f_cmdv, 32'd0);
        check("lit_abort_cmd_held", cmd_data, 32'h0000_0003);
        set_bytes(8'hC0, 8'h00, 8'h00, 8'h00, 8'h07);
        do_frame(40, 1'b1, 8);
        check("lit_cmd_after_abort", cmd_data, 32'h0000_0007);

        // Reset in the middle of a buffer read
        while (fifo_q.size() < 24) fifo_q.push_back(8'($urandom));
        set_bytes(8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00);
        run_frame(20, 1'b0, 1'b0, 6);
        reset_n = 1'b0;
        #1;
        check("mid_rst_miso", {31'b0, spi_miso}, 32'd0);
        check("mid_rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
        check("mid_rst_cmd_data", cmd_data, 32'd0);
        check("mid_rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("mid_rst_wr_data", wr_data, 32'd0);
        check("mid_rst_buf_rd_req", {31'b0, buf_rd_req}, 32'd0);
        check("mid_rst_frame_active", {31'b0, frame_active}, 32'd0);
        spi_ss = 1'b1;
        cyc(2);
        spi_clk = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(4);
        m_cmd = 32'h0;
        m_wr  = 32'h0;
        idle_watch(6);

        // Response frame decodes normally after reset
        resp_word = 32'hA1B2_C3D4;
        set_bytes(8'h81, 8'h00, 8'h00, 8'h00, 8'h00);
        do_frame(40, 1'b1, 7);
        check("lit_resp_b0", {24'b0, got_bytes[0]}, 32'h00);
        check("lit_resp_b1", {24'b0, got_bytes[1]}, 32'hA1);
        check("lit_resp_b2", {24'b0, got_bytes[2]}, 32'hB2);
        check("lit_resp_b3", {24'b0, got_bytes[3]}, 32'hC3);
        check("lit_resp_b4", {24'b0, got_bytes[4]}, 32'hD4);

        // Unknown opcode: silent MISO, no strobes
        set_bytes(8'h55, 8'hC0, 8'h12, 8'h34, 8'h56);
        frame_bytes[5] = 8'h78;
        do_frame(48, 1'b1, 6);
        orv = 8'h00;
        for (int k = 0; k < 6; k++) orv = orv | got_bytes[k];
        check("lit_ignore_miso", {24'b0, orv}, 32'd0);
        check("lit_ignore_strobes", f_cmdv + f_wrv + f_req, 32'd0);

        // Randomized frames
        for (int t = 0; t < 24; t++) begin
            int sel;
            int nb;
            int nbits;
            sel = $urandom_range(4, 0);
            nb  = $urandom_range(8, 1);
            for (int k = 0; k < 24; k++) frame_bytes[k] = 8'($urandom);
            case (sel)
                0: frame_bytes[0] = 8'hC0;
                1: frame_bytes[0] = 8'hC2;
                2: frame_bytes[0] = 8'h81;
                3: frame_bytes[0] = 8'h03;
                default: begin
                    while (frame_bytes[0] == 8'hC0 || frame_bytes[0] == 8'hC2 ||
                           frame_bytes[0] == 8'h81 || frame_bytes[0] == 8'h03)
                        frame_bytes[0] = 8'($urandom);
                end
            endcase
            nbits = nb * 8;
            if ($urandom_range(3, 0) == 0) nbits = nbits - int'($urandom_range(7, 1));
            resp_word = $urandom;
            while (fifo_q.size() < 24) fifo_q.push_back(8'($urandom));
            do_frame(nbits, 1'($urandom_range(1, 0)), int'($urandom_range(9, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
